// File: rtl/atm_pin_fsm.sv
// ATM PIN entry controller: collects BCD digits, compares against the card PIN and
// blocks after MAX_TRIES failures. Optional inactivity timeout under ATM_PIN_TIMEOUT_EN.
module atm_pin_fsm #(
  parameter int unsigned PIN_DIGITS  = 4,
  parameter int unsigned MAX_TRIES   = 3,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tarjeta_recibida,
  input  logic                    digito_stb,
  input  logic [3:0]              digito,
  input  logic [4*PIN_DIGITS-1:0] pin_correcto,
  output logic                    fin,
  output logic                    autorizado,
  output logic                    pin_incorrecto,
  output logic                    advertencia,
  output logic                    bloqueo,
  output logic [2:0]              intentos
);

  localparam int unsigned CntW = (PIN_DIGITS > 1) ? $clog2(PIN_DIGITS) : 1;

  typedef enum logic [4:0] {
    StIdle       = 5'b00001,
    StRecibiendo = 5'b00010,
    StComparar   = 5'b00100,
    StAutorizado = 5'b01000,
    StBloqueo    = 5'b10000
  } state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         count_q, count_d;
  logic [4*PIN_DIGITS-1:0] digits_q, digits_d;
  logic [2:0]              intentos_q, intentos_d;
  logic                    fin_q, fin_d;
  logic                    autorizado_q, autorizado_d;
  logic                    pin_inc_q, pin_inc_d;
  logic                    advertencia_q, advertencia_d;
  logic                    bloqueo_q, bloqueo_d;
  logic                    accept;
  logic                    timeout_hit;

  assign accept = digito_stb && (digito <= 4'd9);

`ifdef ATM_PIN_TIMEOUT_EN
  localparam int unsigned TimerW = $clog2(TIMEOUT_CYC + 1);

  logic [TimerW-1:0] timer_q, timer_d;

  // Runs only while staying in PIN entry; any accepted digit or state change restarts it.
  always_comb begin
    timer_d = '0;
    if (state_q == StRecibiendo && state_d == StRecibiendo && !accept) begin
      timer_d = timer_q + TimerW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  assign timeout_hit = (state_q == StRecibiendo) && (timer_q == TimerW'(TIMEOUT_CYC - 1));
`else
  // Timeout disabled: constant-zero, no counter is built.
  assign timeout_hit = 1'b0 & (TIMEOUT_CYC == 0);
`endif

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    digits_d   = digits_q;
    intentos_d = intentos_q;
    fin_d      = 1'b0;
    pin_inc_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (tarjeta_recibida) begin
          state_d    = StRecibiendo;
          count_d    = '0;
          digits_d   = '0;
          intentos_d = '0;
        end
      end
      StRecibiendo: begin
        if (!tarjeta_recibida || (!accept && timeout_hit)) begin
          state_d    = StIdle;
          count_d    = '0;
          digits_d   = '0;
          intentos_d = '0;
        end else if (accept) begin
          for (int unsigned i = 0; i < PIN_DIGITS; i++) begin
            if (count_q == CntW'(i)) begin
              digits_d[i*4 +: 4] = digito;
            end
          end
          if (count_q == CntW'(PIN_DIGITS - 1)) begin
            state_d = StComparar;
            count_d = '0;
          end else begin
            count_d = count_q + CntW'(1);
          end
        end
      end
      StComparar: begin
        if (!tarjeta_recibida) begin
          state_d    = StIdle;
          count_d    = '0;
          digits_d   = '0;
          intentos_d = '0;
        end else if (digits_q == pin_correcto) begin
          state_d = StAutorizado;
        end else begin
          pin_inc_d  = 1'b1;
          intentos_d = intentos_q + 3'd1;
          if (intentos_q + 3'd1 == 3'(MAX_TRIES)) begin
            state_d = StBloqueo;
          end else begin
            state_d  = StRecibiendo;
            count_d  = '0;
            digits_d = '0;
          end
        end
      end
      StAutorizado: begin
        if (!tarjeta_recibida) begin
          state_d    = StIdle;
          fin_d      = 1'b1;
          count_d    = '0;
          digits_d   = '0;
          intentos_d = '0;
        end
      end
      StBloqueo: begin
        state_d = StBloqueo;
      end
      default: begin
        state_d    = StIdle;
        count_d    = '0;
        digits_d   = '0;
        intentos_d = '0;
      end
    endcase

    autorizado_d  = (state_d == StAutorizado);
    bloqueo_d     = (state_d == StBloqueo);
    advertencia_d = (state_d == StRecibiendo) && (intentos_d == 3'(MAX_TRIES - 1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      count_q       <= '0;
      digits_q      <= '0;
      intentos_q    <= '0;
      fin_q         <= 1'b0;
      autorizado_q  <= 1'b0;
      pin_inc_q     <= 1'b0;
      advertencia_q <= 1'b0;
      bloqueo_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      digits_q      <= digits_d;
      intentos_q    <= intentos_d;
      fin_q         <= fin_d;
      autorizado_q  <= autorizado_d;
      pin_inc_q     <= pin_inc_d;
      advertencia_q <= advertencia_d;
      bloqueo_q     <= bloqueo_d;
    end
  end

  assign fin            = fin_q;
  assign autorizado     = autorizado_q;
  assign pin_incorrecto = pin_inc_q;
  assign advertencia    = advertencia_q;
  assign bloqueo        = bloqueo_q;
  assign intentos       = intentos_q;

endmodule

// File: tb/tb_atm_pin_fsm.sv
// Directed bench for atm_pin_fsm with PIN_DIGITS=4, MAX_TRIES=3, TIMEOUT_CYC=8, PIN 1-2-3-4.
module tb_atm_pin_fsm;

`ifdef ATM_PIN_TIMEOUT_EN
  localparam bit TimeoutOn = 1'b1;
`else
  localparam bit TimeoutOn = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        tarjeta_recibida;
  logic        digito_stb;
  logic [3:0]  digito;
  logic [15:0] pin_correcto;
  logic        fin;
  logic        autorizado;
  logic        pin_incorrecto;
  logic        advertencia;
  logic        bloqueo;
  logic [2:0]  intentos;

  int unsigned total;
  int unsigned passed;

  atm_pin_fsm #(
    .PIN_DIGITS (4),
    .MAX_TRIES  (3),
    .TIMEOUT_CYC(8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .tarjeta_recibida(tarjeta_recibida),
    .digito_stb      (digito_stb),
    .digito          (digito),
    .pin_correcto    (pin_correcto),
    .fin             (fin),
    .autorizado      (autorizado),
    .pin_incorrecto  (pin_incorrecto),
    .advertencia     (advertencia),
    .bloqueo         (bloqueo),
    .intentos        (intentos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic key(input logic [3:0] d);
    digito     = d;
    digito_stb = 1'b1;
    tick();
    digito_stb = 1'b0;
    digito     = 4'd0;
  endtask

  task automatic pin4(input logic [3:0] a, b, c, d);
    key(a);
    key(b);
    key(c);
    key(d);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Packed as {fin, autorizado, pin_incorrecto, advertencia, bloqueo, intentos[2:0]}.
  task automatic outs(input string tag, input logic f, a, p, w, b, input logic [2:0] n);
    check(tag, {fin, autorizado, pin_incorrecto, advertencia, bloqueo, intentos},
          {f, a, p, w, b, n});
  endtask

  initial begin
    total            = 0;
    passed           = 0;
    reset            = 1'b0;
    tarjeta_recibida = 1'b0;
    digito_stb       = 1'b0;
    digito           = 4'd0;
    pin_correcto     = 16'h4321;

    tick(2);
    outs("reset_state", 0, 0, 0, 0, 0, 3'd0);
    reset = 1'b1;
    tick();

    // Correct PIN, then card removal.
    tarjeta_recibida = 1'b1;
    tick();
    key(4'd1); key(4'd2); key(4'd3); key(4'd4);
    outs("compare_cycle", 0, 0, 0, 0, 0, 3'd0);
    tick();
    outs("authorized", 0, 1, 0, 0, 0, 3'd0);
    tick();
    outs("auth_held", 0, 1, 0, 0, 0, 3'd0);
    tarjeta_recibida = 1'b0;
    tick();
    outs("fin_pulse", 1, 0, 0, 0, 0, 3'd0);
    tick();
    outs("fin_single", 0, 0, 0, 0, 0, 3'd0);

    // Two wrong PINs, then correct.
    tarjeta_recibida = 1'b1;
    tick();
    pin4(4'd1, 4'd1, 4'd1, 4'd1);
    tick();
    outs("wrong1", 0, 0, 1, 0, 0, 3'd1);
    tick();
    outs("wrong1_after", 0, 0, 0, 0, 0, 3'd1);
    pin4(4'd1, 4'd1, 4'd1, 4'd1);
    tick();
    outs("wrong2_warn", 0, 0, 1, 1, 0, 3'd2);
    tick();
    outs("warn_held", 0, 0, 0, 1, 0, 3'd2);
    pin4(4'd1, 4'd2, 4'd3, 4'd4);
    tick();
    outs("auth_after_2fail", 0, 1, 0, 0, 0, 3'd2);
    tarjeta_recibida = 1'b0;
    tick();
    check("fin_after_2fail", {7'd0, fin}, 8'd1);
    tick();

    // Three wrong PINs block.
    tarjeta_recibida = 1'b1;
    tick();
    pin4(4'd1, 4'd1, 4'd1, 4'd1);
    tick();
    pin4(4'd1, 4'd1, 4'd1, 4'd1);
    tick();
    pin4(4'd9, 4'd9, 4'd9, 4'd9);
    tick();
    outs("blocked", 0, 0, 1, 0, 1, 3'd3);
    tick();
    outs("blocked_held", 0, 0, 0, 0, 1, 3'd3);
    tarjeta_recibida = 1'b0;
    tick(2);
    outs("blocked_card_out", 0, 0, 0, 0, 1, 3'd3);
    tarjeta_recibida = 1'b1;
    tick();
    pin4(4'd1, 4'd2, 4'd3, 4'd4);
    tick(2);
    outs("blocked_digits", 0, 0, 0, 0, 1, 3'd3);
    #2 reset = 1'b0;
    #1;
    outs("blocked_async_reset", 0, 0, 0, 0, 0, 3'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    // Card already present: first edge after release must leave IDLE.
    tick();
    pin4(4'd1, 4'd2, 4'd3, 4'd4);
    tick();
    outs("auth_first_edge", 0, 1, 0, 0, 0, 3'd0);

    // Invalid digit ignored.
    tarjeta_recibida = 1'b0;
    tick();
    tarjeta_recibida = 1'b1;
    tick();
    key(4'd1); key(4'hA); key(4'd2); key(4'd3); key(4'd4);
    outs("invalid_ignored", 0, 0, 0, 0, 0, 3'd0);
    tick();
    outs("auth_invalid", 0, 1, 0, 0, 0, 3'd0);

    // Removal mid-entry.
    tarjeta_recibida = 1'b0;
    tick();
    tarjeta_recibida = 1'b1;
    tick();
    key(4'd1); key(4'd2);
    tarjeta_recibida = 1'b0;
    tick();
    outs("removed_mid", 0, 0, 0, 0, 0, 3'd0);
    tick();
    outs("removed_mid_idle", 0, 0, 0, 0, 0, 3'd0);

    // Removal wins over same-cycle final digit.
    tarjeta_recibida = 1'b1;
    tick();
    key(4'd1); key(4'd2); key(4'd3);
    tarjeta_recibida = 1'b0;
    key(4'd4);
    tick();
    outs("removal_wins", 0, 0, 0, 0, 0, 3'd0);

    // Async reset mid-entry with warning active.
    tarjeta_recibida = 1'b1;
    tick();
    pin4(4'd5, 4'd5, 4'd5, 4'd5);
    tick();
    pin4(4'd5, 4'd5, 4'd5, 4'd5);
    tick();
    key(4'd1); key(4'd2);
    outs("pre_reset_warn", 0, 0, 0, 1, 0, 3'd2);
    #2 reset = 1'b0;
    #1;
    outs("async_reset_mid", 0, 0, 0, 0, 0, 3'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    pin4(4'd1, 4'd2, 4'd3, 4'd4);
    tick();
    outs("auth_after_reset", 0, 1, 0, 0, 0, 3'd0);

    // Inactivity: one digit, then 8 quiet cycles.
    tarjeta_recibida = 1'b0;
    tick();
    tarjeta_recibida = 1'b1;
    tick();
    key(4'd1);
    tick(8);
    outs("idle_wait", 0, 0, 0, 0, 0, 3'd0);
    key(4'd2); key(4'd3); key(4'd4);
    tick();
    check("timeout_effect", {6'd0, fin, autorizado}, {6'd0, 1'b0, !TimeoutOn});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/atm_pin_fsm.md
ATM_PIN_FSM -- requirements
Module: atm_pin_fsm

Interface
REQ-001 SHALL have parameter PIN_DIGITS, default 4: digits per PIN, legal range 1..8.
REQ-002 SHALL have parameter MAX_TRIES, default 3: failed comparisons before block, legal range 1..7.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1000: allowed inactivity cycles in PIN entry; used only with TIMEOUT_EN.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port tarjeta_recibida, input, 1: level, card present.
REQ-007 SHALL have port digito_stb, input, 1: one-cycle valid qualifier for digito.
REQ-008 SHALL have port digito, input, 4: BCD digit; values 10..15 are invalid.
REQ-009 SHALL have port pin_correcto, input, 4*PIN_DIGITS: stored PIN, digit 0 (first entered) in bits [3:0]; stable while the card is present.
REQ-010 SHALL have port fin, output, 1: one-cycle pulse at normal session end.
REQ-011 SHALL have port autorizado, output, 1: level, high in AUTORIZADO.
REQ-012 SHALL have port pin_incorrecto, output, 1: one-cycle pulse per failed comparison.
REQ-013 SHALL have port advertencia, output, 1: level, high in RECIBIENDO_PIN when intentos == MAX_TRIES-1.
REQ-014 SHALL have port bloqueo, output, 1: level, high in BLOQUEO.
REQ-015 SHALL have port intentos, output, 3: failed-attempt count.

Function
REQ-016 SHALL implement one-hot states IDLE, RECIBIENDO_PIN, COMPARAR, AUTORIZADO, BLOQUEO; all outputs registered.
REQ-017 IDLE: tarjeta_recibida=1 -> RECIBIENDO_PIN next edge; digit count, digit register and intentos cleared.
REQ-018 RECIBIENDO_PIN: digito_stb with digito<=9 stores the digit at index = count and increments count; digito>9 is ignored with no count change.
REQ-019 Acceptance of digit PIN_DIGITS-1 -> COMPARAR next edge.
REQ-020 COMPARAR lasts exactly one cycle: match -> AUTORIZADO; mismatch -> pin_incorrecto pulse and intentos+1.
REQ-021 On mismatch, intentos+1 == MAX_TRIES -> BLOQUEO; otherwise -> RECIBIENDO_PIN with count and digit register cleared.
REQ-022 Latency: last digit sampled at edge N -> COMPARAR after edge N, AUTORIZADO/pin_incorrecto visible after edge N+1.
REQ-023 AUTORIZADO: held while tarjeta_recibida=1; card removal -> IDLE with fin=1 for one cycle.
REQ-024 BLOQUEO is sticky: exit only via reset; card removal and digits are ignored; fin is never pulsed.
REQ-025 Card removal in RECIBIENDO_PIN or COMPARAR -> IDLE with no fin and no pin_incorrecto; removal wins over a same-cycle final digit.
REQ-026 digito_stb outside RECIBIENDO_PIN SHALL be ignored.
REQ-027 Unreachable or illegal state encodings -> IDLE next edge.

Reset
REQ-028 reset=0 SHALL asynchronously force state IDLE, intentos=0, count=0, digit register=0, and fin, autorizado, pin_incorrecto, advertencia, bloqueo all 0, including mid-entry and in BLOQUEO.
REQ-029 First transition out of IDLE SHALL occur on the first rising edge after reset deasserts.

Configuration
REQ-030 With macro ATM_PIN_TIMEOUT_EN defined, an inactivity counter runs in RECIBIENDO_PIN, clears on each accepted digit and on state entry, and on reaching TIMEOUT_CYC forces IDLE like card removal (no fin, intentos cleared).
REQ-031 Without ATM_PIN_TIMEOUT_EN, no counter is synthesised and RECIBIENDO_PIN waits indefinitely.

Verification (PIN_DIGITS=4, MAX_TRIES=3, pin_correcto=16'h4321)
REQ-032 Card in, digits 1,2,3,4 -> autorizado=1 two edges after digit 4; card out -> fin single pulse, IDLE.
REQ-033 Two wrong PINs 1,1,1,1 -> two pin_incorrecto pulses, intentos=2, advertencia=1; correct PIN next -> autorizado=1.
REQ-034 Three wrong PINs -> bloqueo=1, intentos=3; card removal and digits leave bloqueo=1; reset=0 -> all outputs 0.
REQ-035 Digits 1,A,2,3,4 -> A ignored, authorized; card removed after digit 2 -> IDLE, fin=0, intentos=0.
REQ-036 Reset asserted asynchronously between clock edges mid-entry -> outputs 0 immediately; new card plus 1,2,3,4 -> authorized.
REQ-037 With ATM_PIN_TIMEOUT_EN and TIMEOUT_CYC=8: one digit, then 8 idle cycles -> IDLE, fin=0; without the macro, state remains RECIBIENDO_PIN.
